// File: rtl/button_debouncer.sv
// Dual-channel push-button synchroniser and debouncer with one-cycle press strobes.
// Optional BUTTON_LOCKOUT_EN adds a registered stage that blanks both channels while both are held.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic i_clk_25MHz,
    input  logic i_reset_n,
    input  logic i_left_btn,
    input  logic i_right_btn,
    output logic o_left_debounced,
    output logic o_right_debounced,
    output logic o_left_press,
    output logic o_right_press
);

    localparam int unsigned CountWidth = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CountWidth-1:0] CountLast = CountWidth'(DEBOUNCE_CYCLES - 1);
    localparam logic [CountWidth-1:0] CountOne  = CountWidth'(1);
    localparam logic [CountWidth-1:0] CountMax  = '1;

    typedef enum logic [1:0] {
        StReleased,
        StPressCheck,
        StPressed,
        StReleaseCheck
    } state_e;

    logic [1:0] btn_raw;
    logic [1:0] fsm_level;
    logic [1:0] fsm_press;

    assign btn_raw = {i_right_btn, i_left_btn};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sample;
        state_e                 state_q, state_d;
        logic [CountWidth-1:0]  count_q, count_d;
        logic                   level_q, level_d;
        logic                   press_q, press_d;

        always_ff @(posedge i_clk_25MHz) begin
            if (!i_reset_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[ch]};
            end
        end

        assign sample = sync_q[SYNC_STAGES-1];

        always_ff @(posedge i_clk_25MHz) begin
            if (!i_reset_n) begin
                state_q <= StReleased;
                count_q <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                level_q <= level_d;
                press_q <= press_d;
            end
        end

        always_comb begin
            state_d = state_q;
            count_d = count_q;
            unique case (state_q)
                StReleased: begin
                    if (sample) begin
                        state_d = StPressCheck;
                        count_d = CountOne;
                    end
                end
                StPressCheck: begin
                    if (!sample) begin
                        state_d = StReleased;
                        count_d = '0;
                    end else if (count_q == CountLast) begin
                        state_d = StPressed;
                        count_d = '0;
                    end else if (count_q != CountMax) begin
                        count_d = count_q + CountOne;
                    end
                end
                StPressed: begin
                    if (!sample) begin
                        state_d = StReleaseCheck;
                        count_d = CountOne;
                    end
                end
                StReleaseCheck: begin
                    if (sample) begin
                        state_d = StPressed;
                        count_d = '0;
                    end else if (count_q == CountLast) begin
                        state_d = StReleased;
                        count_d = '0;
                    end else if (count_q != CountMax) begin
                        count_d = count_q + CountOne;
                    end
                end
                default: begin
                    state_d = StReleased;
                    count_d = '0;
                end
            endcase
        end

        // Outputs are registered copies of the next state, so they align with the state register.
        always_comb begin
            level_d = (state_d == StPressed) || (state_d == StReleaseCheck);
            press_d = (state_q == StPressCheck) && (state_d == StPressed);
        end

        assign fsm_level[ch] = level_q;
        assign fsm_press[ch] = press_q;
    end

`ifdef BUTTON_LOCKOUT_EN
    logic       both_held;
    logic [1:0] out_level_q;
    logic [1:0] out_press_q;

    assign both_held = &fsm_level;

    always_ff @(posedge i_clk_25MHz) begin
        if (!i_reset_n) begin
            out_level_q <= '0;
            out_press_q <= '0;
        end else begin
            out_level_q <= fsm_level & {2{~both_held}};
            out_press_q <= fsm_press & {2{~both_held}};
        end
    end

    assign o_left_debounced  = out_level_q[0];
    assign o_right_debounced = out_level_q[1];
    assign o_left_press      = out_press_q[0];
    assign o_right_press     = out_press_q[1];
`else
    assign o_left_debounced  = fsm_level[0];
    assign o_right_debounced = fsm_level[1];
    assign o_left_press      = fsm_press[0];
    assign o_right_press     = fsm_press[1];
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus randomized bursts,
// compared against a run-length reference model of the debounce rules.
module tb_button_debouncer;

    localparam int Cycles = 4;
    localparam int Sync   = 2;
`ifdef BUTTON_LOCKOUT_EN
    localparam int Lat = Sync + Cycles + 1;
`else
    localparam int Lat = Sync + Cycles;
`endif

    logic clk;
    logic rst_n;
    logic lb;
    logic rb;
    logic left_deb, right_deb, left_press, right_press;
    logic [3:0] obs;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: delay line of raw samples, per-channel run of samples differing from level.
    bit pipe_l[$];
    bit pipe_r[$];
    int run[2];
    bit m_level[2];
    bit m_press[2];
    bit l_level[2];
    bit l_press[2];

    button_debouncer #(
        .DEBOUNCE_CYCLES(Cycles),
        .SYNC_STAGES    (Sync)
    ) dut (
        .i_clk_25MHz      (clk),
        .i_reset_n        (rst_n),
        .i_left_btn       (lb),
        .i_right_btn      (rb),
        .o_left_debounced (left_deb),
        .o_right_debounced(right_deb),
        .o_left_press     (left_press),
        .o_right_press    (right_press)
    );

    assign obs = {left_deb, right_deb, left_press, right_press};

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic model_edge(input bit rn, input bit l, input bit r);
        bit s[2];
        bit both;
        both = m_level[0] & m_level[1];
        if (!rn) begin
            pipe_l.delete();
            pipe_r.delete();
            for (int i = 0; i < Sync; i++) begin
                pipe_l.push_back(1'b0);
                pipe_r.push_back(1'b0);
            end
            for (int c = 0; c < 2; c++) begin
                run[c] = 0; m_level[c] = 0; m_press[c] = 0; l_level[c] = 0; l_press[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                l_level[c] = m_level[c] & ~both;
                l_press[c] = m_press[c] & ~both;
            end
            s[0] = pipe_l.pop_front();
            s[1] = pipe_r.pop_front();
            pipe_l.push_back(l);
            pipe_r.push_back(r);
            for (int c = 0; c < 2; c++) begin
                m_press[c] = 1'b0;
                if (s[c] != m_level[c]) begin
                    run[c]++;
                    if (run[c] == Cycles) begin
                        m_level[c] = s[c];
                        m_press[c] = s[c];
                        run[c] = 0;
                    end
                end else begin
                    run[c] = 0;
                end
            end
        end
    endtask

    function automatic logic [3:0] model_vec();
`ifdef BUTTON_LOCKOUT_EN
        return {l_level[0], l_level[1], l_press[0], l_press[1]};
`else
        return {m_level[0], m_level[1], m_press[0], m_press[1]};
`endif
    endfunction

    task automatic step(input bit rn, input bit l, input bit r);
        rst_n = rn;
        lb    = l;
        rb    = r;
        @(posedge clk);
        model_edge(rn, l, r);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            n_checks++;
            if (obs !== 4'b0000) $display("FAIL reset_hold cyc %0d: got %b want 0000", i, obs);
            else n_pass++;
        end
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b1, 1'b0);
            n_checks++;
            if (obs !== {k >= Lat, 1'b0, k == Lat, 1'b0})
                $display("FAIL reset_release k %0d: got %b want %b", k, obs,
                         {k >= Lat, 1'b0, k == Lat, 1'b0});
            else n_pass++;
            n_checks++;
            if (obs !== model_vec()) $display("FAIL reset_model k %0d: got %b want %b", k, obs,
                                              model_vec());
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pat[i], 1'b0);
            n_checks++;
            if (obs !== 4'b0000) $display("FAIL bounce_active i %0d: got %b want 0000", i, obs);
            else n_pass++;
        end
        for (int j = 1; j <= 8; j++) begin
            step(1'b1, 1'b1, 1'b0);
            n_checks++;
            if (obs !== {j >= Lat, 1'b0, j == Lat, 1'b0})
                $display("FAIL bounce_hold j %0d: got %b want %b", j, obs,
                         {j >= Lat, 1'b0, j == Lat, 1'b0});
            else n_pass++;
            n_checks++;
            if (obs !== model_vec()) $display("FAIL bounce_model j %0d: got %b want %b", j, obs,
                                              model_vec());
            else n_pass++;
        end
    endtask

    task automatic test_short_pulse();
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 1'b1, i < 3);
            n_checks++;
            if ({right_deb, right_press} !== 2'b00)
                $display("FAIL short_pulse i %0d: got %b want 00", i, {right_deb, right_press});
            else n_pass++;
            n_checks++;
            if (obs !== model_vec()) $display("FAIL short_model i %0d: got %b want %b", i, obs,
                                              model_vec());
            else n_pass++;
        end
    endtask

    task automatic test_release();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int j = 1; j <= 9; j++) begin
            step(1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs !== {j < Lat, 3'b000})
                $display("FAIL release j %0d: got %b want %b", j, obs, {j < Lat, 3'b000});
            else n_pass++;
            n_checks++;
            if (obs !== model_vec()) $display("FAIL release_model j %0d: got %b want %b", j, obs,
                                              model_vec());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (obs !== 4'b0000) $display("FAIL reset_mid_in: got %b want 0000", obs);
        else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b1, 1'b0);
            n_checks++;
            if (obs !== {k >= Lat, 1'b0, k == Lat, 1'b0})
                $display("FAIL reset_mid k %0d: got %b want %b", k, obs,
                         {k >= Lat, 1'b0, k == Lat, 1'b0});
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] want;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 10; j++) begin
            step(1'b1, 1'b1, 1'b1);
`ifdef BUTTON_LOCKOUT_EN
            want = 4'b0000;
`else
            want = {j >= Lat, j >= Lat, j == Lat, j == Lat};
`endif
            n_checks++;
            if (obs !== want) $display("FAIL simul_press j %0d: got %b want %b", j, obs, want);
            else n_pass++;
        end
        for (int j = 1; j <= 10; j++) begin
            step(1'b1, 1'b1, 1'b0);
`ifdef BUTTON_LOCKOUT_EN
            want = {j >= Lat, 3'b000};
`else
            want = {1'b1, j < Lat, 2'b00};
`endif
            n_checks++;
            if (obs !== want) $display("FAIL simul_release j %0d: got %b want %b", j, obs, want);
            else n_pass++;
            n_checks++;
            if (obs !== model_vec()) $display("FAIL simul_model j %0d: got %b want %b", j, obs,
                                              model_vec());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit cur[2];
        int rem[2];
        bit rn;
        cur[0] = 0; cur[1] = 0; rem[0] = 0; rem[1] = 0;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (rem[c] == 0) begin
                    cur[c] = ~cur[c];
                    rem[c] = $urandom_range(1, 8);
                end
                rem[c]--;
            end
            rn = ($urandom_range(0, 149) != 0);
            step(rn, cur[0], cur[1]);
            n_checks++;
            if (obs !== model_vec()) $display("FAIL random i %0d: got %b want %b", i, obs,
                                              model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        lb    = 1'b0;
        rb    = 1'b0;
        @(negedge clk);
        test_reset();
        test_bounce();
        test_short_pulse();
        test_release();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Dual-channel push-button conditioner sitting directly upstream of the ship movement block. Synchronises the raw left/right button pins into the 25 MHz domain, filters contact bounce with a per-channel counter state machine, and drives the clean levels consumed as `i_left_debounced` / `i_right_debounced`. Also emits one-cycle press strobes for later consumers such as fire or menu logic.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable synchronised samples required to accept a level change (10 ms at 25 MHz). Legal range 2..2^20.
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchroniser. Legal range 2..4.
- `i_clk_25MHz`  in  1  system clock; all logic on rising edge.
- `i_reset_n`  in  1  one clock; reset is synchronous and active-low.
- `i_left_btn`  in  1  raw left button pin, asynchronous, active-high (1 = pressed).
- `i_right_btn`  in  1  raw right button pin, asynchronous, active-high.
- `o_left_debounced`  out  1  filtered left level; feeds ship `i_left_debounced`.
- `o_right_debounced`  out  1  filtered right level; feeds ship `i_right_debounced`.
- `o_left_press`  out  1  one-cycle strobe on accepted left 0->1.
- `o_right_press`  out  1  one-cycle strobe on accepted right 0->1.

## Operation
- Each channel has an identical, independent pipeline: synchroniser, then counter, then FSM.
- Synchroniser: `SYNC_STAGES` flops. Its last stage is the sample `s`. All stages reset to 0.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. It saturates and never wraps.
- FSM states and transitions:
  - RELEASED: output 0. If `s`=1, load count=1 and go to PRESS_CHECK.
  - PRESS_CHECK: output 0.
    - If `s`=0, clear count and return to RELEASED. No output change and no strobe.
    - If `s`=1 and count=`DEBOUNCE_CYCLES`-1, go to PRESSED, set output 1, and pulse the press strobe.
    - Otherwise increment count.
  - PRESSED: output 1. If `s`=0, load count=1 and go to RELEASE_CHECK.
  - RELEASE_CHECK: output 1.
    - If `s`=1, clear count and return to PRESSED. No strobe.
    - If `s`=0 and count=`DEBOUNCE_CYCLES`-1, go to RELEASED and set output 0.
    - Otherwise increment count.
- Release produces no strobe.
- Any single-cycle glitch in `s` restarts qualification from zero.
- Both channels may change in the same cycle. They are fully independent unless `BUTTON_LOCKOUT_EN` is defined.
- Reset (`i_reset_n`=0 at a rising edge), including mid-qualification:
  - all FSMs go to RELEASED, counters to 0, synchronisers to 0;
  - all four outputs are 0 from the next cycle.
  - A button held through reset is re-qualified from scratch after reset deasserts.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Pad-to-output latency for a clean edge is `SYNC_STAGES` + `DEBOUNCE_CYCLES` clocks. Worked example, defaults 2/250000: press applied before edge 0 gives output high after edge 250001.
- Strobe is high for exactly the cycle in which the debounced output first reads 1.
- Minimum accepted pulse width is `DEBOUNCE_CYCLES` cycles of synchronised input. Shorter pulses are dropped entirely.
- No back-pressure and no handshake. Outputs are free-running levels and strobes.

## Configuration
- `BUTTON_LOCKOUT_EN`
  - Defined: a lockout stage follows the FSMs. While both channels are in PRESSED or RELEASE_CHECK, `o_left_debounced` and `o_right_debounced` are both forced to 0 and both strobes are suppressed. When one channel releases, the other output reappears on the next cycle with no strobe. Internal FSMs are unaffected. Adds one register stage, so the latencies above increase by 1.
  - Undefined: outputs come directly from the FSMs. Simultaneous presses pass straight through, both 1, and the ship block resolves them.

## Test plan
Bench settings: `DEBOUNCE_CYCLES`=4, `SYNC_STAGES`=2.
- Reset and idle: hold `i_reset_n`=0 for 3 cycles with buttons=1 -> all outputs 0. Release reset -> `o_left_debounced` rises 6 cycles later; `o_left_press` is high for that single cycle.
- Bounce rejection: left toggles 1,0,1,0,1 on alternate cycles, then is held 1 -> no output or strobe during bouncing; output rises 6 cycles after the final 0->1.
- Short pulse: right=1 for 3 cycles, then 0 -> `o_right_debounced` and `o_right_press` stay 0 throughout.
- Release: left held, output 1, then left=0 with a 1-cycle glitch back to 1 at its second cycle -> output stays 1 until 6 cycles after the glitch ends; no strobe on release.
- Reset mid-qualification: left=1 for 4 cycles, then `i_reset_n`=0 for 1 cycle, left still 1 -> output 0 and re-rises 6 cycles after reset deasserts.
- Simultaneous press: both buttons held from cycle 0.
  - Undefined macro: both outputs and both strobes assert at cycle 6.
  - `BUTTON_LOCKOUT_EN`: both outputs stay 0 and no strobes. After right releases, `o_left_debounced` reads 1 on cycle 7 after right's FSM leaves RELEASE_CHECK, with no strobe.
